// File: rtl/spi_mem_pkg.sv
// Shared constants and types for the SPI memory responder.
package spi_mem_pkg;

  // Serial-memory command opcodes understood by the responder
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Width of the address sent on the wire, regardless of implemented bits
  localparam int ADDR_BITS_SPI = 24;

  // Transaction phases
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    RD     = 3'd3,
    WR     = 3'd4,
    IGNORE = 3'd5
  } state_t;

  // True for opcodes that proceed to the address phase
  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Oversampling front end: synchronises sck/ss/mosi into clk and
// produces single-cycle edge strobes for sck and ss.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic spi_sck,
  input  logic spi_ss,
  input  logic spi_mosi,
  output logic mosi_sync,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_rise,
  output logic ss_fall
);

  // Bit order: {mosi, ss, sck}; idle levels are mosi=0, ss=1, sck=0
  localparam logic [2:0] IDLE_LEVELS = 3'b010;

  logic [2:0] pin_vec;
  logic [2:0] sync_vec;
  logic       sck_d_reg;
  logic       ss_d_reg;

  assign pin_vec = {spi_mosi, spi_ss, spi_sck};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      // Shift chain; reset loads the idle level so no false edge follows reset
      always_ff @(posedge clk) begin
        if (srst) begin
          chain_reg <= {SYNC_STAGES{IDLE_LEVELS[gi]}};
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_vec[gi]};
        end
      end

      assign sync_vec[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  // One extra flop per clock/select line for edge detection
  always_ff @(posedge clk) begin
    if (srst) begin
      sck_d_reg <= 1'b0;
      ss_d_reg  <= 1'b1;
    end else begin
      sck_d_reg <= sync_vec[0];
      ss_d_reg  <= sync_vec[1];
    end
  end

  assign mosi_sync = sync_vec[2];
  assign sck_rise  = sync_vec[0] & ~sck_d_reg;
  assign sck_fall  = ~sync_vec[0] & sck_d_reg;
  assign ss_rise   = sync_vec[1] & ~ss_d_reg;
  assign ss_fall   = ~sync_vec[1] & ss_d_reg;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder emulating a serial RAM: READ/WRITE with a 24-bit
// address, served from a byte-wide cyc/ack memory port.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_cyc,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [7:0]        mem_dat_w,
  input  logic [7:0]        mem_dat_r,
  input  logic              mem_ack,
  output logic              busy
);

  localparam logic [1:0]        LAST_ADDR_BYTE = 2'(ADDR_BITS_SPI / 8 - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE       = ADDR_W'(1);

  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic ss_rise;
  logic ss_fall;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (wb_clk),
    .srst     (wb_rst),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .mosi_sync(mosi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_rise  (ss_rise),
    .ss_fall  (ss_fall)
  );

  state_t            state_reg;
  state_t            state_next;
  logic [2:0]        bit_cnt_reg;
  logic [1:0]        byte_cnt_reg;
  logic [7:0]        shift_in_reg;
  logic [7:0]        shift_out_reg;
  logic [7:0]        rd_buf_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] mem_adr_reg;
  logic [7:0]        dat_w_reg;
  logic              is_read_reg;
  logic              miso_reg;
  logic              cyc_reg;
  logic              we_reg;

  logic [7:0]        rx_byte;
  logic              byte_done;
  logic              addr_done;
  logic              mem_free;
  logic [ADDR_W-1:0] addr_shifted;
  logic [ADDR_W-1:0] addr_inc;

  // Byte as it will look once the bit sampled this cycle is shifted in
  assign rx_byte      = {shift_in_reg[6:0], mosi_s};
  assign byte_done    = sck_rise && (bit_cnt_reg == 3'd7);
  assign addr_done    = byte_done && (byte_cnt_reg == LAST_ADDR_BYTE);
  // A new request may be launched in the same cycle the previous one is acked
  assign mem_free     = !cyc_reg || mem_ack;
  // Upper SPI address bits simply fall off the top of the register
  assign addr_shifted = {addr_reg[ADDR_W-2:0], mosi_s};
  assign addr_inc     = addr_reg + ADDR_ONE;

  // State register
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; deselect wins over everything
  always_comb begin
    state_next = state_reg;
    if (ss_rise) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (ss_fall) state_next = CMD;
        CMD:     if (byte_done) state_next = is_known_cmd(rx_byte) ? ADDR : IGNORE;
        ADDR:    if (addr_done) state_next = is_read_reg ? RD : WR;
        default: state_next = state_reg;
      endcase
    end
  end

  // Outputs derived from state; miso drops in the same cycle ss rises
  always_comb begin
    busy     = (state_reg != IDLE);
    spi_miso = (state_reg == RD) && miso_reg && !ss_rise;
  end

  assign mem_cyc   = cyc_reg;
  assign mem_we    = we_reg;
  assign mem_adr   = mem_adr_reg;
  assign mem_dat_w = dat_w_reg;

  // Shift registers, counters and the memory handshake
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      bit_cnt_reg   <= '0;
      byte_cnt_reg  <= '0;
      shift_in_reg  <= '0;
      shift_out_reg <= '0;
      rd_buf_reg    <= '0;
      addr_reg      <= '0;
      mem_adr_reg   <= '0;
      dat_w_reg     <= '0;
      is_read_reg   <= 1'b0;
      miso_reg      <= 1'b0;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
    end else begin
      // Completing request: runs regardless of state so an aborted
      // transaction still finishes its cycle; read data only kept in RD
      if (cyc_reg && mem_ack) begin
        cyc_reg <= 1'b0;
        we_reg  <= 1'b0;
        if (we_reg) begin
          addr_reg <= addr_inc;
        end else if (state_reg == RD && !ss_rise) begin
          rd_buf_reg <= mem_dat_r;
        end
      end

      if (ss_rise || ss_fall) begin
        // Any partial byte is dropped at a select boundary
        bit_cnt_reg  <= '0;
        byte_cnt_reg <= '0;
        shift_in_reg <= '0;
        miso_reg     <= 1'b0;
      end else begin
        case (state_reg)
          CMD: begin
            if (sck_rise) begin
              shift_in_reg <= rx_byte;
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              if (byte_done) is_read_reg <= (rx_byte == CMD_READ);
            end
          end
          ADDR: begin
            if (sck_rise) begin
              shift_in_reg <= rx_byte;
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              addr_reg     <= addr_shifted;
              if (byte_done) byte_cnt_reg <= addr_done ? 2'd0 : byte_cnt_reg + 2'd1;
              // Fetch the first read byte as soon as the address is complete
              if (addr_done && is_read_reg && mem_free) begin
                cyc_reg     <= 1'b1;
                we_reg      <= 1'b0;
                mem_adr_reg <= addr_shifted;
              end
            end
          end
          WR: begin
            if (sck_rise) begin
              shift_in_reg <= rx_byte;
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              if (byte_done && mem_free) begin
                cyc_reg     <= 1'b1;
                we_reg      <= 1'b1;
                mem_adr_reg <= addr_reg;
                dat_w_reg   <= rx_byte;
              end
            end
          end
          RD: begin
            if (sck_fall) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd0) begin
                // Byte boundary: present the fetched byte and prefetch the next
                shift_out_reg <= rd_buf_reg;
                miso_reg      <= rd_buf_reg[7];
                addr_reg      <= addr_inc;
                if (mem_free) begin
                  cyc_reg     <= 1'b1;
                  we_reg      <= 1'b0;
                  mem_adr_reg <= addr_inc;
                end
              end else begin
                shift_out_reg <= {shift_out_reg[6:0], 1'b0};
                miso_reg      <= shift_out_reg[6];
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Randomised self-checking bench for spi_mem_responder.
module tb_spi_mem_responder;

  localparam int HALF = 8;   // wb_clk cycles per SCK half period
  localparam int SYNC = 2;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        spi_sck;
  logic        spi_ss;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_cyc;
  logic        mem_we;
  logic [15:0] mem_adr;
  logic [7:0]  mem_dat_w;
  logic [7:0]  mem_dat_r;
  logic        mem_ack;
  logic        busy;

  always #5 wb_clk = ~wb_clk;

  spi_mem_responder #(
    .ADDR_W     (16),
    .SYNC_STAGES(SYNC)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_cyc  (mem_cyc),
    .mem_we   (mem_we),
    .mem_adr  (mem_adr),
    .mem_dat_w(mem_dat_w),
    .mem_dat_r(mem_dat_r),
    .mem_ack  (mem_ack),
    .busy     (busy)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [7:0]  dat;
  } req_t;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  sim_mem   [0:65535];  // storage behind the memory port
  logic [7:0]  model_mem [0:65535];  // what memory must contain per protocol
  req_t        exp_q[$];
  logic [7:0]  rx_q[$];
  int          slave_lat_force = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Memory slave: acks 1..3 cycles after mem_cyc rises
  initial begin
    int lat;
    mem_ack   = 1'b0;
    mem_dat_r = 8'h00;
    forever begin
      @(posedge wb_clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_cyc) begin
        lat = (slave_lat_force != 0) ? slave_lat_force : int'($urandom_range(1, 3));
        repeat (lat - 1) begin @(posedge wb_clk); #1; end
        if (mem_we) sim_mem[mem_adr] = mem_dat_w;
        else mem_dat_r = sim_mem[mem_adr];
        mem_ack = 1'b1;
      end
    end
  end

  // Per-cycle compare: request stream, handshake rule, idle/selected outputs
  initial begin
    logic cyc_prev;
    logic ack_prev;
    int   ss_hi;
    int   ss_lo;
    req_t e;
    cyc_prev = 1'b0;
    ack_prev = 1'b0;
    ss_hi    = 0;
    ss_lo    = 0;
    forever begin
      @(negedge wb_clk);
      if (wb_rst === 1'b0) begin
        if (mem_cyc && !cyc_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: we=%0b adr=%04h, no request expected", mem_we, mem_adr);
          end else begin
            e = exp_q.pop_front();
            check("req_we", 32'(mem_we), 32'(e.we));
            check("req_adr", 32'(mem_adr), 32'(e.adr));
            if (e.we) check("req_dat", 32'(mem_dat_w), 32'(e.dat));
          end
        end
        if (cyc_prev && !mem_cyc) check("cyc_held_until_ack", 32'(ack_prev), 32'd1);
        if (ss_hi > SYNC + 3) begin
          check("busy_idle", 32'(busy), 32'd0);
          check("miso_idle", 32'(spi_miso), 32'd0);
        end
        if (ss_lo > SYNC + 3) check("busy_selected", 32'(busy), 32'd1);
      end
      if (spi_ss) begin ss_hi++; ss_lo = 0; end
      else begin ss_lo++; ss_hi = 0; end
      cyc_prev = mem_cyc;
      ack_prev = mem_ack;
    end
  end

  task automatic half_period();
    repeat (HALF) @(negedge wb_clk);
  endtask

  // Clock out the top nbits of tx, sampling miso before each rising edge
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      half_period();
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      half_period();
      spi_sck = 1'b0;
    end
  endtask

  task automatic select();
    spi_ss = 1'b0;
    half_period();
  endtask

  task automatic deselect();
    half_period();
    spi_ss = 1'b1;
    for (int w = 0; w < 200 && (exp_q.size() != 0 || mem_cyc); w++) @(negedge wb_clk);
    check("reqs_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2 * HALF) @(negedge wb_clk);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] rx;
    logic [7:0] rx_or;
    rx_or = 8'h00;
    spi_bits(cmd, 8, rx);        rx_or |= rx;
    spi_bits(a[23:16], 8, rx);   rx_or |= rx;
    spi_bits(a[15:8], 8, rx);    rx_or |= rx;
    spi_bits(a[7:0], 8, rx);     rx_or |= rx;
    check("hdr_miso_zero", 32'(rx_or), 32'd0);
  endtask

  // READ of n bytes: one fetch plus one prefetch per loaded byte, and the
  // final falling SCK loads byte n, so addresses a..a+n+1 are requested
  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0]  rx;
    logic [15:0] ad;
    rx_q.delete();
    for (int k = 0; k <= n + 1; k++) begin
      ad = a[15:0] + 16'(k);
      exp_q.push_back('{we: 1'b0, adr: ad, dat: 8'h00});
    end
    select();
    send_header(8'h03, a);
    for (int k = 0; k < n; k++) begin
      ad = a[15:0] + 16'(k);
      spi_bits(8'(int'($urandom)), 8, rx);
      check("rd_data", 32'(rx), 32'(model_mem[ad]));
      rx_q.push_back(rx);
    end
    deselect();
    $display("read  adr=%06h n=%0d", a, n);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [7:0] d[$]);
    logic [7:0]  rx;
    logic [15:0] ad;
    for (int k = 0; k < d.size(); k++) begin
      ad = a[15:0] + 16'(k);
      exp_q.push_back('{we: 1'b1, adr: ad, dat: d[k]});
      model_mem[ad] = d[k];
    end
    select();
    send_header(8'h02, a);
    for (int k = 0; k < d.size(); k++) spi_bits(d[k], 8, rx);
    deselect();
    $display("write adr=%06h n=%0d", a, d.size());
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  rx;
    logic [7:0]  wq[$];
    logic [23:0] a;
    int          n;

    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      sim_mem[i]   = b;
      model_mem[i] = b;
    end
    sim_mem[16'h0010] = 8'hA5; model_mem[16'h0010] = 8'hA5;
    sim_mem[16'hFFFF] = 8'h11; model_mem[16'hFFFF] = 8'h11;
    sim_mem[16'h0000] = 8'h22; model_mem[16'h0000] = 8'h22;
    sim_mem[16'h0001] = 8'h33; model_mem[16'h0001] = 8'h33;

    // Reset with the bus active: sck toggling, ss low
    wb_rst = 1'b1; spi_ss = 1'b0; spi_sck = 1'b0; spi_mosi = 1'b1;
    @(negedge wb_clk); spi_sck = 1'b1;
    @(negedge wb_clk); spi_sck = 1'b0;
    check("rst_mem_cyc", 32'(mem_cyc), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_adr", 32'(mem_adr), 32'd0);
    check("rst_mem_dat_w", 32'(mem_dat_w), 32'd0);
    $display("reset done");
    spi_ss = 1'b1; spi_mosi = 1'b0; wb_rst = 1'b0;
    repeat (4 * HALF) @(negedge wb_clk);

    // Single-byte read
    do_read(24'h000010, 1);
    check("lit_read_a5", 32'(rx_q[0]), 32'h0A5);

    // Burst read across the address wrap
    do_read(24'h00FFFF, 3);
    check("lit_wrap_0", 32'(rx_q[0]), 32'h011);
    check("lit_wrap_1", 32'(rx_q[1]), 32'h022);
    check("lit_wrap_2", 32'(rx_q[2]), 32'h033);

    // Write then read back
    wq = '{8'hDE, 8'hAD};
    do_write(24'h001234, wq);
    check("lit_sim_mem_1234", 32'(sim_mem[16'h1234]), 32'h0DE);
    check("lit_sim_mem_1235", 32'(sim_mem[16'h1235]), 32'h0AD);
    do_read(24'h001234, 2);
    check("lit_rb_0", 32'(rx_q[0]), 32'h0DE);
    check("lit_rb_1", 32'(rx_q[1]), 32'h0AD);

    // Unknown command: miso silent, still selected, no memory traffic
    select();
    spi_bits(8'h9F, 8, rx);
    for (int k = 0; k < 2; k++) begin
      spi_bits(8'(int'($urandom)), 8, rx);
      check("ignore_miso", 32'(rx), 32'd0);
    end
    check("ignore_busy", 32'(busy), 32'd1);
    deselect();
    $display("ignore cmd=9f");

    // Abort during a write data byte after 5 bits: nothing written
    select();
    send_header(8'h02, 24'h002000);
    spi_bits(8'h5A, 5, rx);
    deselect();
    $display("abort write adr=002000");
    do_read(24'h002000, 1);

    // Abort while the read fetch is outstanding
    slave_lat_force = 3;
    exp_q.push_back('{we: 1'b0, adr: 16'h0300, dat: 8'h00});
    select();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 7, rx);
    spi_mosi = 1'b0;
    half_period();
    spi_sck = 1'b1;
    @(negedge wb_clk);
    spi_ss = 1'b1;
    for (int w = 0; w < 20 && busy; w++) @(negedge wb_clk);
    check("abort_rd_busy", 32'(busy), 32'd0);
    check("abort_rd_cyc_held", 32'(mem_cyc), 32'd1);
    check("abort_rd_miso", 32'(spi_miso), 32'd0);
    for (int w = 0; w < 20 && mem_cyc; w++) @(negedge wb_clk);
    check("abort_rd_cyc_dropped", 32'(mem_cyc), 32'd0);
    half_period();
    spi_sck = 1'b0;
    repeat (2 * HALF) @(negedge wb_clk);
    check("abort_rd_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    slave_lat_force = 0;
    $display("abort read adr=000300");
    do_read(24'h000300, 1);

    // Randomised traffic; upper SPI address byte is junk and must be ignored
    for (int t = 0; t < 20; t++) begin
      a = 24'($urandom);
      if ($urandom_range(0, 3) == 0) a[15:0] = 16'hFFFE;
      n = int'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
        do_write(a, wq);
      end else begin
        do_read(a, n);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
